// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone classic bus bundle with master/slave views
interface wshb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  ack, dat_sm, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output ack, dat_sm, err, rty
   );
endinterface

// File: rtl/mire_wshb_writer.sv
// rtl/mire_wshb_writer.sv - Wishbone write master filling the framebuffer with a grid test pattern
// Optional MIRE_ONESHOT_EN: stop after one frame instead of rewriting continuously.
module mire_wshb_writer #(
   parameter int          HDISP    = 800,
   parameter int          VDISP    = 480,
   parameter int          BURST    = 64,
   parameter logic [31:0] BASE_ADR = 32'h0
) (
   input  logic     clk,
   input  logic     rst_n,
   wshb_if.master   wshb_ifm,
   output logic     frame_done
);

   localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

   typedef enum logic [1:0] {RELEASE, WRITE, STOP} state_t;

   state_t        state, state_next;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [BW-1:0] burst_cnt;
   logic          accept;
   logic          x_last;
   logic          frame_last;
   logic          burst_last;
   logic [31:0]   offset;
   logic [31:0]   x_w;
   logic [31:0]   y_w;
   logic          white;
   logic          unused_ok;

   assign accept     = (state == WRITE) && wshb_ifm.ack;
   assign x_last     = (x == X_LAST);
   assign frame_last = x_last && (y == Y_LAST);
   assign burst_last = (burst_cnt == B_LAST);

   always_comb begin
      state_next = state;
      case (state)
         RELEASE: state_next = WRITE;
         WRITE: begin
            if (accept && (burst_last || frame_last)) begin
`ifdef MIRE_ONESHOT_EN
               state_next = frame_last ? STOP : RELEASE;
`else
               state_next = RELEASE;
`endif
            end
         end
         STOP:    state_next = STOP;
         default: state_next = RELEASE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RELEASE;
         x          <= '0;
         y          <= '0;
         burst_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= accept && frame_last;
         if (accept) begin
            if (x_last) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
            burst_cnt <= (burst_last || frame_last) ? '0 : burst_cnt + BW'(1);
         end
      end
   end

   // Address and pixel are pure functions of the counters, so they hold through wait states.
   assign x_w    = 32'(x);
   assign y_w    = 32'(y);
   assign offset = y_w * 32'(HDISP) + x_w;
   assign white  = (x_w[3:0] == 4'd0) || (y_w[3:0] == 4'd0);

   assign wshb_ifm.cyc    = (state == WRITE);
   assign wshb_ifm.stb    = (state == WRITE);
   assign wshb_ifm.we     = 1'b1;
   assign wshb_ifm.adr    = BASE_ADR + {offset[29:0], 2'b00};
   assign wshb_ifm.dat_ms = white ? 32'h00FF_FFFF : 32'h0000_0000;
   assign wshb_ifm.sel    = 4'hF;
   assign wshb_ifm.cti    = 3'b000;
   assign wshb_ifm.bte    = 2'b00;

   assign unused_ok = &{1'b0, wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty};

endmodule

// File: tb/tb_mire_wshb_writer.sv
// tb/tb_mire_wshb_writer.sv - randomized self-checking bench for mire_wshb_writer
module tb_mire_wshb_writer;

   localparam int          HDISP = 32;
   localparam int          VDISP = 4;
   localparam int          BURST = 64;
   localparam logic [31:0] BASE  = 32'h0;
   localparam int          NPIX  = HDISP * VDISP;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_done;

   wshb_if bus();

   int checks = 0;
   int errors = 0;

   // reference model: linear pixel index and writes issued in the current cyc
   int pix;
   int bcnt;
   bit exp_release;
   bit fd_pending;
   bit stopped;

   always #5 clk = ~clk;

   assign bus.dat_sm = 32'h0;
   assign bus.err    = 1'b0;
   assign bus.rty    = 1'b0;

   mire_wshb_writer #(
      .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .BASE_ADR(BASE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wshb_ifm(bus.master),
      .frame_done(frame_done)
   );

   function automatic logic [31:0] exp_dat(input int p);
      int px, py;
      px = p % HDISP;
      py = p / HDISP;
      return ((px % 16 == 0) || (py % 16 == 0)) ? 32'h00FF_FFFF : 32'h0;
   endfunction

   function automatic int pick_waits(input int mode);
      return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
   endfunction

   task automatic model_reset();
      pix = 0;
      bcnt = 0;
      exp_release = 1'b1;
      fd_pending = 1'b0;
      stopped = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.ack = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cyc !== 1'b0 || bus.stb !== 1'b0)
         $display("FAIL reset_cyc got cyc=%b stb=%b want 0 0", bus.cyc, bus.stb);
      else checks = checks;
      if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) errors++;
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_done got %b want 0", frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // mode: fixed wait states per write, or -1 for random 0..3
   task automatic test_traffic(input int mode, input int cycles, input string tag);
      int  waits;
      bit  last;
      waits = pick_waits(mode);
      for (int c = 0; c < cycles; c++) begin
         checks++;
         if (frame_done !== fd_pending) begin
            errors++;
            $display("FAIL %s frame_done cyc%0d got %b want %b", tag, c, frame_done, fd_pending);
         end
         fd_pending = 1'b0;
         if (stopped || exp_release) begin
            checks++;
            if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin
               errors++;
               $display("FAIL %s idle cyc%0d got cyc=%b stb=%b want 0", tag, c, bus.cyc, bus.stb);
            end
            exp_release = 1'b0;
            bus.ack = 1'($urandom_range(0, 1));
         end else begin
            checks++;
            if (bus.cyc !== 1'b1 || bus.stb !== 1'b1) begin
               errors++;
               $display("FAIL %s active cyc%0d got cyc=%b stb=%b want 1", tag, c, bus.cyc, bus.stb);
            end
            checks++;
            if (bus.adr !== BASE + 32'(4 * pix)) begin
               errors++;
               $display("FAIL %s adr cyc%0d got %h want %h", tag, c, bus.adr, BASE + 32'(4 * pix));
            end
            checks++;
            if (bus.dat_ms !== exp_dat(pix)) begin
               errors++;
               $display("FAIL %s dat cyc%0d pix%0d got %h want %h", tag, c, pix, bus.dat_ms, exp_dat(pix));
            end
            checks++;
            if ({bus.we, bus.sel, bus.cti, bus.bte} !== {1'b1, 4'hF, 3'b000, 2'b00}) begin
               errors++;
               $display("FAIL %s ctl cyc%0d got we=%b sel=%h cti=%b bte=%b", tag, c,
                        bus.we, bus.sel, bus.cti, bus.bte);
            end
            if (waits > 0) begin
               bus.ack = 1'b0;
               waits--;
            end else begin
               bus.ack = 1'b1;
               waits = pick_waits(mode);
               last = (pix == NPIX - 1);
               pix = (pix + 1) % NPIX;
               bcnt++;
               if (bcnt == BURST || last) begin
                  bcnt = 0;
                  exp_release = 1'b1;
               end
               if (last) begin
                  fd_pending = 1'b1;
`ifdef MIRE_ONESHOT_EN
                  stopped = 1'b1;
                  exp_release = 1'b0;
`endif
               end
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_write();
      test_traffic(100, 6, "stall");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got cyc=%b stb=%b want 0 0", bus.cyc, bus.stb);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      test_traffic(0, 20, "restart");
   endtask

   initial begin
      bus.ack = 1'b0;
      test_reset();
      test_traffic(0, 70, "burst");
      test_traffic(3, 60, "wait3");
      test_traffic(-1, 800, "random");
      test_traffic(0, 300, "wrap");
      test_reset_mid_write();
`ifdef MIRE_ONESHOT_EN
      test_traffic(0, 1000, "oneshot");
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
